// File: rtl/rsa_pkg.sv
// Shared defaults and FSM encoding for the modular exponentiation controller.
package rsa_pkg;
    localparam int WIDTH_DEF  = 512;
    localparam int ELEN_W_DEF = 10;

    typedef enum logic [2:0] {
        IDLE,
        SQ_START,
        SQ_WAIT,
        MUL_START,
        MUL_WAIT,
        POST_START,
        POST_WAIT
    } state_t;
endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery core;
// the final multiply by 1 converts the accumulator out of Montgomery form.
module mont_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ELEN_W = ELEN_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [WIDTH-1:0]  x_mont,
    input  logic [WIDTH-1:0]  r_mod_m,
    input  logic [WIDTH-1:0]  exp,
    input  logic [ELEN_W-1:0] exp_len,
    output logic              mult_start,
    output logic [WIDTH-1:0]  mult_a,
    output logic [WIDTH-1:0]  mult_b,
    input  logic [WIDTH-1:0]  mult_result,
    input  logic              mult_done,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result
);
    localparam logic [ELEN_W-1:0] WLEN = ELEN_W'(WIDTH);
    localparam logic [WIDTH-1:0]  ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_q, x_q, exp_q;
    logic [ELEN_W-1:0] idx, len_eff;
    logic              accept, last_bit, cur_bit;

    assign len_eff  = (exp_len > WLEN) ? WLEN : exp_len;
    // A start arriving with done is held off one cycle so done always completes cleanly.
    assign accept   = start && !done;
    assign last_bit = (idx == '0);
    // exp_q is left-aligned at load, so the bit under examination is always the MSB.
    assign cur_bit  = exp_q[WIDTH-1];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (accept) state_nxt = (len_eff == '0) ? POST_START : SQ_START;
            SQ_START:   state_nxt = SQ_WAIT;
            MUL_START:  state_nxt = MUL_WAIT;
            POST_START: state_nxt = POST_WAIT;
            SQ_WAIT: if (mult_done) begin
                if (cur_bit)       state_nxt = MUL_START;
                else if (last_bit) state_nxt = POST_START;
                else               state_nxt = SQ_START;
            end
            MUL_WAIT:  if (mult_done) state_nxt = last_bit ? POST_START : SQ_START;
            POST_WAIT: if (mult_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q        <= '0;
            x_q        <= '0;
            exp_q      <= '0;
            idx        <= '0;
            result     <= '0;
            mult_a     <= '0;
            mult_b     <= '0;
            mult_start <= 1'b0;
            done       <= 1'b0;
        end else begin
            mult_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    x_q   <= x_mont;
                    exp_q <= exp << (WLEN - len_eff);
                    a_q   <= r_mod_m;
                    idx   <= len_eff - 1'b1;
                end
                SQ_START: begin
                    mult_start <= 1'b1;
                    mult_a     <= a_q;
                    mult_b     <= a_q;
                end
                MUL_START: begin
                    mult_start <= 1'b1;
                    mult_a     <= a_q;
                    mult_b     <= x_q;
                end
                POST_START: begin
                    mult_start <= 1'b1;
                    mult_a     <= a_q;
                    mult_b     <= ONE;
                end
                SQ_WAIT: if (mult_done) begin
                    a_q <= mult_result;
                    if (!cur_bit && !last_bit) begin
                        idx   <= idx - 1'b1;
                        exp_q <= exp_q << 1;
                    end
                end
                MUL_WAIT: if (mult_done) begin
                    a_q <= mult_result;
                    if (!last_bit) begin
                        idx   <= idx - 1'b1;
                        exp_q <= exp_q << 1;
                    end
                end
                POST_WAIT: if (mult_done) begin
                    result <= mult_result;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural 10-cycle Montgomery core, operand-order and result scoreboards.
module tb_mont_exp_ctrl;
    localparam int W  = 512;
    localparam int EW = 10;

    typedef logic [W-1:0]   wide_t;
    typedef logic [2*W-1:0] dbl_t;
    typedef struct { wide_t a; wide_t b; } op_t;

    logic          clk = 1'b0, resetn = 1'b1, start = 1'b0;
    wide_t         x_mont = '0, r_mod_m = '0, exp_v = '0;
    logic [EW-1:0] exp_len = '0;
    logic          mult_start, busy, done, mult_done;
    wide_t         mult_a, mult_b, mult_result, result;

    logic  core_done = 1'b0, inj_done = 1'b0;
    wide_t core_res = '0, inj_res = '0, cap_a = '0, cap_b = '0, m_cur = 11;
    int    cnt = 0;

    int    n_tests = 0, n_fail = 0, pulse_cnt = 0, done_cnt = 0;
    op_t   exp_ops[$];
    wide_t exp_res[$];
    op_t   op_mon;
    wide_t res_mon;

    assign mult_done   = core_done | inj_done;
    assign mult_result = inj_done ? inj_res : core_res;

    mont_exp_ctrl #(.WIDTH(W), .ELEN_W(EW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .x_mont(x_mont), .r_mod_m(r_mod_m), .exp(exp_v), .exp_len(exp_len),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_result(mult_result), .mult_done(mult_done),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Bit-serial Montgomery product a*b*2^-W mod m.
    function automatic wide_t mm(input wide_t a, input wide_t b, input wide_t m);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[W-1:0];
    endfunction

    function automatic wide_t mulmod(input wide_t a, input wide_t b, input wide_t m);
        dbl_t p;
        p = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, m};
        return p[W-1:0];
    endfunction

    function automatic wide_t to_mont(input wide_t x, input wide_t m);
        dbl_t p;
        p = {x, {W{1'b0}}} % {{W{1'b0}}, m};
        return p[W-1:0];
    endfunction

    function automatic wide_t modexp(input wide_t x, input wide_t e, input int len, input wide_t m);
        wide_t r;
        r = 1;
        for (int i = len - 1; i >= 0; i--) begin
            r = mulmod(r, r, m);
            if (e[i]) r = mulmod(r, x, m);
        end
        return r;
    endfunction

    function automatic wide_t rand_wide();
        wide_t r;
        for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural core plus both scoreboards.
    always @(negedge clk) begin
        if (!resetn) begin
            cnt       <= 0;
            core_done <= 1'b0;
        end else begin
            core_done <= 1'b0;
            if (mult_start) begin
                cap_a <= mult_a;
                cap_b <= mult_b;
                cnt   <= 10;
                pulse_cnt++;
                n_tests++;
                if (exp_ops.size() == 0) begin
                    n_fail++;
                    $display("FAIL op_unexpected pulse=%0d a=%h", pulse_cnt, mult_a);
                end else begin
                    op_mon = exp_ops.pop_front();
                    if (mult_a !== op_mon.a || mult_b !== op_mon.b) begin
                        n_fail++;
                        $display("FAIL op_order pulse=%0d a=%h b=%h exp_a=%h exp_b=%h",
                                 pulse_cnt, mult_a[127:0], mult_b[127:0], op_mon.a[127:0], op_mon.b[127:0]);
                    end
                end
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    n_tests++;
                    if (mult_a !== cap_a || mult_b !== cap_b) begin
                        n_fail++;
                        $display("FAIL op_hold a=%h b=%h exp_a=%h exp_b=%h",
                                 mult_a[127:0], mult_b[127:0], cap_a[127:0], cap_b[127:0]);
                    end
                    core_done <= 1'b1;
                    core_res  <= mm(cap_a, cap_b, m_cur);
                end
            end
            if (done) begin
                done_cnt++;
                n_tests++;
                if (exp_res.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected result=%h", result[127:0]);
                end else begin
                    res_mon = exp_res.pop_front();
                    if (result !== res_mon) begin
                        n_fail++;
                        $display("FAIL result got=%h exp=%h", result[127:0], res_mon[127:0]);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pushes expected operands and result, then raises start until the block goes busy.
    task automatic launch(input wide_t x, input wide_t e, input int len, input wide_t m);
        wide_t xm, rm, a;
        int    le;
        bit    ok;
        le = (len > W) ? W : len;
        xm = to_mont(x, m);
        rm = to_mont(1, m);
        a  = rm;
        for (int i = le - 1; i >= 0; i--) begin
            exp_ops.push_back('{a: a, b: a});
            a = mm(a, a, m);
            if (e[i]) begin
                exp_ops.push_back('{a: a, b: xm});
                a = mm(a, xm, m);
            end
        end
        exp_ops.push_back('{a: a, b: wide_t'(1)});
        exp_res.push_back(modexp(x, e, le, m));
        m_cur   = m;
        x_mont  = xm;
        r_mod_m = rm;
        exp_v   = e;
        exp_len = EW'(len);
        start   = 1'b1;
        ok      = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step(1);
            if (busy) begin ok = 1'b1; break; end
        end
        start = 1'b0;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL start_timeout busy=%0b exp=1", busy); end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            step(1);
            if (!busy) begin ok = 1'b1; break; end
        end
        step(1);
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || mult_start !== 1'b0 || result !== '0 ||
            mult_a !== '0 || mult_b !== '0) begin
            n_fail++;
            $display("FAIL reset_state busy=%0b done=%0b ms=%0b res=%h exp=0", busy, done, mult_start, result[31:0]);
        end
        step(3);
        resetn = 1'b1;
        step(2);
    endtask

    task automatic test_zero_len();
        int p0, d0; bit ok;
        p0 = pulse_cnt; d0 = done_cnt;
        launch(7, 4'b1011, 0, 11);
        wait_idle(ok);
        n_tests++;
        if (!ok || pulse_cnt - p0 != 1 || done_cnt - d0 != 1 || result !== wide_t'(1)) begin
            n_fail++;
            $display("FAIL zero_len ok=%0b pulses=%0d dones=%0d result=%0d exp=1/1/1", ok, pulse_cnt - p0, done_cnt - d0, result);
        end
    endtask

    task automatic test_order();
        int p0; bit ok;
        p0 = pulse_cnt;
        launch(7, 4'b1011, 4, 11);
        wait_idle(ok);
        n_tests++;
        if (!ok || pulse_cnt - p0 != 8 || exp_ops.size() != 0 || result !== wide_t'(7)) begin
            n_fail++;
            $display("FAIL order_1011 ok=%0b pulses=%0d left=%0d result=%0d exp=8/0/7", ok, pulse_cnt - p0, exp_ops.size(), result);
        end
    endtask

    task automatic test_back_to_back();
        int p0; bit ok;
        p0 = pulse_cnt;
        launch(2, 12, 4, 13);
        // Stray start while a square is in flight must be ignored.
        for (int c = 0; c < 100 && pulse_cnt == p0; c++) step(1);
        step(2);
        start = 1'b1; step(1); start = 1'b0;
        wait_idle(ok);
        n_tests++;
        if (!ok || pulse_cnt - p0 != 7 || result !== wide_t'(1)) begin
            n_fail++;
            $display("FAIL start_while_busy ok=%0b pulses=%0d result=%0d exp=7/1", ok, pulse_cnt - p0, result);
        end
        // Immediately chain a second run.
        p0 = pulse_cnt;
        launch(3, 5, 3, 11);
        wait_idle(ok);
        n_tests++;
        if (!ok || pulse_cnt - p0 != 6 || result !== wide_t'(1)) begin
            n_fail++;
            $display("FAIL back_to_back ok=%0b pulses=%0d result=%0d exp=6/1", ok, pulse_cnt - p0, result);
        end
        // Stray mult_done in IDLE.
        p0 = pulse_cnt;
        inj_res = 99; inj_done = 1'b1; step(1); inj_done = 1'b0;
        step(15);
        n_tests++;
        if (busy !== 1'b0 || pulse_cnt != p0 || result !== wide_t'(1)) begin
            n_fail++;
            $display("FAIL done_in_idle busy=%0b pulses=%0d result=%0d exp=0/0/1", busy, pulse_cnt - p0, result);
        end
    endtask

    task automatic test_reset_mid();
        int p0, d0; bit ok;
        p0 = pulse_cnt;
        launch(7, 4'b1011, 4, 11);
        for (int c = 0; c < 200 && pulse_cnt < p0 + 2; c++) step(1);
        step(3);
        d0 = done_cnt;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || result !== '0 || mult_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid busy=%0b result=%0d ms=%0b exp=0/0/0", busy, result, mult_start);
        end
        exp_ops.delete();
        exp_res.delete();
        step(2);
        resetn = 1'b1;
        step(30);
        n_tests++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done dones=%0d busy=%0b exp=0/0", done_cnt - d0, busy);
        end
        launch(2, 12, 4, 13);
        wait_idle(ok);
        n_tests++;
        if (!ok || result !== wide_t'(1)) begin
            n_fail++;
            $display("FAIL reset_rerun ok=%0b result=%0d exp=1", ok, result);
        end
    endtask

    task automatic test_len_clamp();
        wide_t m, x, e; int p0; bit ok;
        m = rand_wide(); m[W-1] = 1'b1; m[0] = 1'b1;
        x = rand_wide() % m;
        e = rand_wide();
        p0 = pulse_cnt;
        launch(x, e, 700, m);
        wait_idle(ok);
        n_tests++;
        if (!ok || pulse_cnt - p0 != W + $countones(e) + 1 || result !== modexp(x, e, W, m)) begin
            n_fail++;
            $display("FAIL len_clamp ok=%0b pulses=%0d exp=%0d", ok, pulse_cnt - p0, W + $countones(e) + 1);
        end
    endtask

    task automatic test_full_ones();
        wide_t m, x; int p0; bit ok;
        m = rand_wide(); m[W-1] = 1'b1; m[0] = 1'b1;
        x = rand_wide() % m;
        p0 = pulse_cnt;
        launch(x, '1, W, m);
        wait_idle(ok);
        n_tests++;
        if (!ok || pulse_cnt - p0 != 1025 || result !== modexp(x, '1, W, m)) begin
            n_fail++;
            $display("FAIL full_ones ok=%0b pulses=%0d exp=1025 result=%h", ok, pulse_cnt - p0, result[127:0]);
        end
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_order();
        test_back_to_back();
        test_reset_mid();
        test_len_clamp();
        test_full_ones();
        step(2);
        n_tests++;
        if (exp_ops.size() != 0 || exp_res.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain ops=%0d res=%0d exp=0/0", exp_ops.size(), exp_res.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
